cmd_encode: RTL and testbench
=============================

// Module: cmd_encode
// PURPOSE
//  Return-path framer for the UART/SDRAM link; the encoder counterpart of the command decoder.
//  On each completed SDRAM read burst, pulls PAYLOAD_LEN bytes from the read FIFO.
//  Sends HEAD_BYTE, the payload bytes, then an 8-bit checksum, one byte at a time, into the UART transmitter.
//  Sits between the read FIFO (SDRAM side) and the UART TX byte interface.
// PARAMETERS
//  HEAD_BYTE    8'h55  first byte of every frame, same header as the host write frame
//  PAYLOAD_LEN  4      payload bytes per frame, range 1..255
//  SUM_EN       1      1: append checksum byte; 0: frame ends after the last payload byte
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  reset; asynchronous, active-low
//  rd_done        in   1  1-cycle pulse: a read burst has been written into the read FIFO
//  rfifo_empty    in   1  read FIFO empty flag
//  rfifo_rd_en    out  1  read FIFO pop, 1-cycle pulse
//  rfifo_rd_data  in   8  read FIFO data, valid the cycle after rfifo_rd_en
//  tx_trig        out  1  1-cycle pulse: start sending tx_data
//  tx_data        out  8  byte to send; held stable from tx_trig until tx_done
//  tx_done        in   1  1-cycle pulse from UART TX: byte fully shifted out
//  busy           out  1  high from frame acceptance to the last tx_done of the frame
//  ovf_err        out  1  1-cycle pulse: rd_done dropped (pending slot already full)
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, pending=0, sum=0, cnt=0. Reset mid-frame aborts the frame; no partial resume.
//  FSM states and transitions:
//   IDLE     rd_done or pending -> HEAD (clear pending, sum=0, cnt=0)
//   HEAD     tx_data=HEAD_BYTE, tx_trig for 1 cycle -> WAIT_TX
//   FETCH    if !rfifo_empty: rfifo_rd_en=1 -> LATCH; else hold in FETCH (no timeout)
//   LATCH    tx_data=rfifo_rd_data, sum+=rfifo_rd_data (mod 256), cnt++, tx_trig -> WAIT_TX
//   SUM      tx_data=sum, tx_trig -> WAIT_TX
//   WAIT_TX  on tx_done:
//            - last byte sent -> IDLE
//            - else if cnt<PAYLOAD_LEN -> FETCH
//            - else if SUM_EN -> SUM
//  - busy=1 in every state except IDLE; it drops the cycle after the final tx_done.
//  - Latency: rd_done in cycle N -> tx_trig (header) in cycle N+2.
//  - Payload byte: tx_done -> tx_trig no earlier than 3 cycles (FETCH, LATCH), with FIFO non-empty.
//  - Exactly one rfifo_rd_en per payload byte; never asserted when rfifo_empty=1.
//  - tx_done is ignored outside WAIT_TX, and ignored in the same cycle as tx_trig.
//  - rd_done while busy sets pending, which is served immediately after return to IDLE.
//  - rd_done while pending is already set: ovf_err pulses; the request is dropped.
//  - rd_done in the same cycle that IDLE consumes pending: counts as a new pending (not overflow).
//  - tx_data changes only in the cycle tx_trig is asserted.
//  - cnt width is 8 bits. Checksum = sum of payload bytes only, header excluded, carry discarded.
// STRUCTURE
//  Shared package: FSM state encoding (localparams IDLE..WAIT_TX), default HEAD_BYTE value.
//  Single flat module with no sub-modules; FSM, payload counter, checksum accumulator and pending flag inline.
// TESTING
//  1. FIFO holds 01,02,03,04; pulse rd_done -> tx bytes 55,01,02,03,04,0A; 4 rd_en; busy falls after 6th tx_done.
//  2. FIFO holds FF,FF,FF,02 -> checksum byte FF (wraps mod 256); SUM_EN=0 instance -> 5 bytes, no checksum.
//  3. FIFO empty after 2 bytes, refilled 50 cycles later -> FSM holds in FETCH; no rd_en while empty; frame completes.
//  4. rd_done twice during a frame -> second frame follows back-to-back; a third rd_done -> ovf_err pulse, no third frame.
//  5. tx_done delayed 200 cycles per byte -> tx_data stable throughout; spurious tx_done in IDLE -> no activity.
//  6. rst_n low during 3rd payload byte -> outputs 0 asynchronously; the next rd_done starts a clean frame at HEAD_BYTE.

Source files
------------

// File: rtl/cmd_encode_pkg.sv
// Shared definitions for the return-path frame encoder.
// Holds the FSM state encoding and the default frame header byte. The
// header matches the one used on host write frames, so both directions of
// the link share one sync pattern.
package cmd_encode_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEAD    = 3'd1,
    FETCH   = 3'd2,
    LATCH   = 3'd3,
    SUM     = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [7:0] HEAD_BYTE_DEF = 8'h55;

endpackage

// File: rtl/cmd_encode.sv
// Return-path framer for the UART/SDRAM link.
// When an SDRAM read burst has landed in the read FIFO, this block sends one
// frame to the UART transmitter, one byte at a time: HEAD_BYTE, then
// PAYLOAD_LEN bytes popped from the FIFO, then (if SUM_EN) the mod-256 sum
// of the payload bytes. A burst that completes while a frame is in flight is
// remembered in a single pending slot. A further burst that arrives while
// that slot is full is dropped, and ovf_err pulses.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   rd_done        in   pulse: a read burst is now in the read FIFO
//   rfifo_empty    in   read FIFO empty flag
//   rfifo_rd_en    out  read FIFO pop pulse
//   rfifo_rd_data  in   FIFO data, valid the cycle after rfifo_rd_en
//   tx_trig        out  pulse: start sending tx_data
//   tx_data        out  byte to send, held from tx_trig until tx_done
//   tx_done        in   pulse: UART has finished shifting the byte out
//   busy           out  a frame is in progress
//   ovf_err        out  pulse: a burst notification was dropped
//
// state   | meaning
// IDLE    | no frame; start one on rd_done or a pending request
// HEAD    | load the header byte and trigger the transmitter
// FETCH   | wait for FIFO data, then pop one byte
// LATCH   | wait for popped data to arrive, then load it and trigger
// SUM     | load the checksum byte and trigger
// WAIT_TX | wait for the UART to finish the current byte
module cmd_encode
  import cmd_encode_pkg::*;
#(
  parameter logic [7:0] HEAD_BYTE   = HEAD_BYTE_DEF,
  parameter int         PAYLOAD_LEN = 4,
  parameter bit         SUM_EN      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_done,
  input  logic       rfifo_empty,
  output logic       rfifo_rd_en,
  input  logic [7:0] rfifo_rd_data,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic       ovf_err
);

  localparam logic [7:0] LEN = 8'(PAYLOAD_LEN);

  state_t     r_state;
  logic       r_pending;
  logic [7:0] r_sum;
  logic [7:0] r_cnt;
  logic       r_sum_sent;
  logic       r_rd_en;
  logic       r_tx_trig;
  logic [7:0] r_tx_data;
  logic       r_busy;
  logic       r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pending  <= 1'b0;
      r_sum      <= 8'h00;
      r_cnt      <= 8'h00;
      r_sum_sent <= 1'b0;
      r_rd_en    <= 1'b0;
      r_tx_trig  <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_tx_trig <= 1'b0;
      r_ovf     <= 1'b0;

      // IDLE consumes the pending slot; a rd_done in that same cycle
      // immediately re-arms it rather than counting as an overflow.
      if (r_state == IDLE) begin
        if (r_pending) r_pending <= rd_done;
      end else if (rd_done) begin
        if (r_pending) r_ovf     <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (rd_done || r_pending) begin
            r_state    <= HEAD;
            r_sum      <= 8'h00;
            r_cnt      <= 8'h00;
            r_sum_sent <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        HEAD: begin
          r_tx_data <= HEAD_BYTE;
          r_tx_trig <= 1'b1;
          r_state   <= WAIT_TX;
        end
        FETCH: begin
          if (!rfifo_empty) begin
            r_rd_en <= 1'b1;
            r_state <= LATCH;
          end
        end
        LATCH: begin
          // The first LATCH cycle is the pop cycle itself; data is valid on
          // the next one, which is the first cycle with the pop deasserted.
          if (!r_rd_en) begin
            r_tx_data <= rfifo_rd_data;
            r_sum     <= r_sum + rfifo_rd_data;
            r_cnt     <= r_cnt + 8'd1;
            r_tx_trig <= 1'b1;
            r_state   <= WAIT_TX;
          end
        end
        SUM: begin
          r_tx_data  <= r_sum;
          r_tx_trig  <= 1'b1;
          r_sum_sent <= 1'b1;
          r_state    <= WAIT_TX;
        end
        WAIT_TX: begin
          // A tx_done coincident with our own trigger belongs to the previous
          // byte (or is spurious) and is ignored.
          if (tx_done && !r_tx_trig) begin
            if (r_cnt < LEN) begin
              r_state <= FETCH;
            end else if (SUM_EN && !r_sum_sent) begin
              r_state <= SUM;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rfifo_rd_en = r_rd_en;
  assign tx_trig     = r_tx_trig;
  assign tx_data     = r_tx_data;
  assign busy        = r_busy;
  assign ovf_err     = r_ovf;

endmodule

// File: tb/tb_cmd_encode.sv
module tb_cmd_encode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rd_done;
  logic rd_done1;
  logic spur_done;
  int   tx_dly;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instance 0: checksum enabled ----------------
  logic       empty0, rd_en0, trig0, done0, busy0, ovf0;
  logic       mdone0 = 1'b0;
  logic [7:0] rdata0 = 8'h00;
  logic [7:0] txd0;
  logic [7:0] fmem0 [256];
  int         wp0 = 0, rp0 = 0, rden0 = 0, eviol0 = 0, dcnt0 = 0;

  assign empty0 = (rp0 == wp0);
  assign done0  = mdone0 | spur_done;

  cmd_encode #(.HEAD_BYTE(8'h55), .PAYLOAD_LEN(4), .SUM_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_done(rd_done),
    .rfifo_empty(empty0), .rfifo_rd_en(rd_en0), .rfifo_rd_data(rdata0),
    .tx_trig(trig0), .tx_data(txd0), .tx_done(done0),
    .busy(busy0), .ovf_err(ovf0)
  );

  // read FIFO and UART TX models
  always @(posedge clk) begin
    if (!rst_n) begin
      rp0    <= wp0;
      dcnt0  <= 0;
      mdone0 <= 1'b0;
    end else begin
      if (rd_en0) begin
        if (empty0) eviol0 <= eviol0 + 1;
        rdata0 <= fmem0[rp0[7:0]];
        rp0    <= rp0 + 1;
        rden0  <= rden0 + 1;
      end
      if (trig0) begin
        dcnt0  <= tx_dly;
        mdone0 <= 1'b0;
      end else if (dcnt0 != 0) begin
        dcnt0  <= dcnt0 - 1;
        mdone0 <= (dcnt0 == 1);
      end else begin
        mdone0 <= 1'b0;
      end
    end
  end

  logic [7:0] log0 [512];
  int         trigc0 [512];
  int         donec0 [512];
  int         txn0 = 0, ndone0 = 0, ovfn0 = 0, chg0 = 0, lastdone0 = 0, bfall0 = 0;
  logic [7:0] pdata0 = 8'h00;
  logic       pbusy0 = 1'b0;

  always @(negedge clk) begin
    if (trig0) begin
      log0[txn0[8:0]]   <= txd0;
      trigc0[txn0[8:0]] <= cyc;
      txn0              <= txn0 + 1;
    end
    if (done0) begin
      donec0[ndone0[8:0]] <= cyc;
      ndone0              <= ndone0 + 1;
      lastdone0           <= cyc;
    end
    if (rst_n && !trig0 && txd0 !== pdata0) chg0 <= chg0 + 1;
    pdata0 <= txd0;
    if (pbusy0 && !busy0) bfall0 <= cyc;
    pbusy0 <= busy0;
    if (ovf0) ovfn0 <= ovfn0 + 1;
  end

  // ---------------- instance 1: checksum disabled ----------------
  logic       empty1, rd_en1, trig1, done1, busy1, ovf1;
  logic       mdone1 = 1'b0;
  logic [7:0] rdata1 = 8'h00;
  logic [7:0] txd1;
  logic [7:0] fmem1 [256];
  int         wp1 = 0, rp1 = 0, rden1 = 0, eviol1 = 0, dcnt1 = 0, txn1 = 0;
  logic [7:0] log1 [64];

  assign empty1 = (rp1 == wp1);
  assign done1  = mdone1 | spur_done;

  cmd_encode #(.HEAD_BYTE(8'h55), .PAYLOAD_LEN(4), .SUM_EN(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst_n), .rd_done(rd_done1),
    .rfifo_empty(empty1), .rfifo_rd_en(rd_en1), .rfifo_rd_data(rdata1),
    .tx_trig(trig1), .tx_data(txd1), .tx_done(done1),
    .busy(busy1), .ovf_err(ovf1)
  );

  always @(posedge clk) begin
    if (!rst_n) begin
      rp1    <= wp1;
      dcnt1  <= 0;
      mdone1 <= 1'b0;
    end else begin
      if (rd_en1) begin
        if (empty1) eviol1 <= eviol1 + 1;
        rdata1 <= fmem1[rp1[7:0]];
        rp1    <= rp1 + 1;
        rden1  <= rden1 + 1;
      end
      if (trig1) begin
        dcnt1  <= tx_dly;
        mdone1 <= 1'b0;
      end else if (dcnt1 != 0) begin
        dcnt1  <= dcnt1 - 1;
        mdone1 <= (dcnt1 == 1);
      end else begin
        mdone1 <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (trig1) begin
      log1[txn1[5:0]] <= txd1;
      txn1            <= txn1 + 1;
    end
  end

  // ---------------- reference model: expected byte streams ----------------
  logic [7:0] exp0 [$];
  logic [7:0] later0 [$];
  logic [7:0] exp1 [$];
  int         cmp0 = 0;
  int         cmp1 = 0;

  task automatic push0(input logic [7:0] b);
    fmem0[wp0[7:0]] = b;
    wp0++;
  endtask

  task automatic push1(input logic [7:0] b);
    fmem1[wp1[7:0]] = b;
    wp1++;
  endtask

  // Frame = header, four payload bytes (MSB first), then payload sum mod 256.
  task automatic load_frame0(input logic [31:0] pay, input int npush);
    int s;
    logic [7:0] b;
    s = 0;
    exp0.push_back(8'h55);
    for (int i = 0; i < 4; i++) begin
      b = pay[31-8*i -: 8];
      s = s + int'(b);
      exp0.push_back(b);
      if (i < npush) push0(b);
      else           later0.push_back(b);
    end
    exp0.push_back(8'(s));
  endtask

  task automatic flush_later0();
    while (later0.size() > 0) push0(later0.pop_front());
  endtask

  task automatic load_frame1(input logic [31:0] pay);
    logic [7:0] b;
    exp1.push_back(8'h55);
    for (int i = 0; i < 4; i++) begin
      b = pay[31-8*i -: 8];
      exp1.push_back(b);
      push1(b);
    end
  endtask

  task automatic pulse_rd0(output int pc);
    pc = cyc;
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
  endtask

  task automatic wait_done0(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !(busy0 == 1'b0 && txn0 >= cmp0 + exp0.size())) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_tmo"}, 32'(n < budget), 1);
  endtask

  task automatic cmp_stream0(input string tag);
    while (exp0.size() > 0) begin
      chk(tag, log0[cmp0[8:0]], exp0.pop_front());
      cmp0++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pc, base, r0, o0, c0, d0, n;
    logic [31:0] pay;

    rst_n = 1'b0; rd_done = 1'b0; rd_done1 = 1'b0; spur_done = 1'b0; tx_dly = 4;
    repeat (3) @(negedge clk);
    chk("rst_trig",  trig0,  0);
    chk("rst_rden",  rd_en0, 0);
    chk("rst_busy",  busy0,  0);
    chk("rst_ovf",   ovf0,   0);
    chk("rst_txd",   txd0,   0);
    chk("rst_busy1", busy1,  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic frame, latency, checksum, busy fall
    base = txn0; r0 = rden0;
    load_frame0(32'h01020304, 4);
    pulse_rd0(pc);
    wait_done0("t1", 500);
    chk("t1_latency", trigc0[base[8:0]] - pc, 2);
    chk("t1_sumlit",  log0[(base + 5) & 511], 8'h0A);
    cmp_stream0("t1_byte");
    chk("t1_rden",    rden0 - r0, 4);
    chk("t1_bfall",   bfall0 - lastdone0, 1);

    // 2: checksum wrap, and the no-checksum instance
    base = txn0;
    load_frame0(32'hFFFFFF02, 4);
    pulse_rd0(pc);
    wait_done0("t2", 500);
    chk("t2_sumlit", log0[(base + 5) & 511], 8'hFF);
    cmp_stream0("t2_byte");
    load_frame1($urandom);
    rd_done1 = 1'b1;
    @(negedge clk);
    rd_done1 = 1'b0;
    n = 0;
    while (n < 500 && !(busy1 == 1'b0 && txn1 >= 5)) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("t2ns_tmo", 32'(n < 500), 1);
    chk("t2ns_len", txn1, 5);
    chk("t2ns_rden", rden1, 4);
    while (exp1.size() > 0) begin
      chk("t2ns_byte", log1[cmp1[5:0]], exp1.pop_front());
      cmp1++;
    end

    // 3: FIFO runs dry mid-frame
    base = txn0; r0 = rden0;
    load_frame0($urandom, 2);
    pulse_rd0(pc);
    repeat (80) @(negedge clk);
    chk("t3_stall_bytes", txn0 - base, 3);
    chk("t3_stall_busy",  busy0, 1);
    chk("t3_stall_rden",  rden0 - r0, 2);
    flush_later0();
    wait_done0("t3", 500);
    cmp_stream0("t3_byte");
    chk("t3_eviol", eviol0, 0);

    // 4: pending request, overflow, and rd_done coincident with pending use
    base = txn0; r0 = rden0; o0 = ovfn0; d0 = ndone0;
    load_frame0($urandom, 4);
    load_frame0($urandom, 4);
    load_frame0($urandom, 4);
    pulse_rd0(pc);
    repeat (5) @(negedge clk);
    pulse_rd0(pc);
    repeat (5) @(negedge clk);
    pulse_rd0(pc);
    n = 0;
    while (n < 500 && busy0) begin
      @(negedge clk);
      n++;
    end
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("t4_fall_tmo", 32'(n < 500), 1);
    wait_done0("t4", 2000);
    chk("t4_b2b", trigc0[(base + 6) & 511] - donec0[(d0 + 5) & 511], 3);
    cmp_stream0("t4_byte");
    chk("t4_ovf",  ovfn0 - o0, 1);
    chk("t4_rden", rden0 - r0, 12);
    repeat (60) @(negedge clk);
    chk("t4_frames", txn0 - base, 18);
    chk("t4_idle",   busy0, 0);

    // 5: slow UART, then a spurious tx_done while idle
    tx_dly = 200; c0 = chg0;
    load_frame0($urandom, 4);
    pulse_rd0(pc);
    wait_done0("t5", 3000);
    cmp_stream0("t5_byte");
    chk("t5_txd_stable", chg0 - c0, 0);
    tx_dly = 3;
    base = txn0; r0 = rden0;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_spur_tx",   txn0 - base, 0);
    chk("t5_spur_rden", rden0 - r0, 0);
    chk("t5_spur_busy", busy0, 0);

    // randomized frames
    for (int k = 0; k < 6; k++) begin
      tx_dly = $urandom_range(1, 6);
      r0 = rden0;
      pay = $urandom;
      load_frame0(pay, 4);
      pulse_rd0(pc);
      wait_done0("rnd", 500);
      cmp_stream0("rnd_byte");
      chk("rnd_rden", rden0 - r0, 4);
    end
    chk("rnd_eviol", eviol0, 0);
    chk("rnd_txd_stable", chg0 - c0, 0);

    // 6: reset during the third payload byte
    tx_dly = 4;
    base = txn0;
    load_frame0($urandom, 4);
    pulse_rd0(pc);
    n = 0;
    while (n < 500 && txn0 < base + 4) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_tmo", 32'(n < 500), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ctl", {trig0, rd_en0, busy0, ovf0}, 4'b0000);
    chk("t6_async_txd", txd0, 0);
    exp0.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp0 = txn0;
    base = txn0;
    chk("t6_post_busy", busy0, 0);
    load_frame0($urandom, 4);
    pulse_rd0(pc);
    wait_done0("t6", 500);
    chk("t6_latency", trigc0[base[8:0]] - pc, 2);
    chk("t6_head",    log0[base[8:0]], 8'h55);
    cmp_stream0("t6_byte");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
